// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath, with memory-ready stalls,
// illegal-opcode flag and retired-instruction counter. Define MULTICYCLE_CTRL_JUMP_EN to enable j.
module multicycle_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PC_write,
  output logic             PC_write_cond,
  output logic             I_or_D,
  output logic             mem_read,
  output logic             mem_write,
  output logic             IR_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             ALU_src_A,
  output logic [1:0]       ALU_src_B,
  output logic [1:0]       ALU_op,
  output logic [1:0]       PC_source,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_retired
);

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
`ifdef MULTICYCLE_CTRL_JUMP_EN
  localparam logic [5:0] OP_J   = 6'b000010;
`endif

`ifdef MULTICYCLE_CTRL_JUMP_EN
  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEM_ADR = 4'd2,
    MEM_RD  = 4'd3,
    MEM_WB  = 4'd4,
    MEM_WR  = 4'd5,
    EXEC    = 4'd6,
    ALU_WB  = 4'd7,
    BRANCH  = 4'd8,
    JUMP    = 4'd9
  } state_t;
`else
  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEM_ADR = 4'd2,
    MEM_RD  = 4'd3,
    MEM_WB  = 4'd4,
    MEM_WR  = 4'd5,
    EXEC    = 4'd6,
    ALU_WB  = 4'd7,
    BRANCH  = 4'd8
  } state_t;
`endif

  state_t           cur_state;
  state_t           nxt_state;
  logic             retire;
  logic             bad_opcode;
  logic [CNT_W-1:0] retired_cnt;

  assign state         = cur_state;
  assign instr_retired = retired_cnt;

  always_comb begin
    nxt_state  = FETCH;
    retire     = 1'b0;
    bad_opcode = 1'b0;
    case (cur_state)
      FETCH:   nxt_state = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: nxt_state = MEM_ADR;
          OP_R:         nxt_state = EXEC;
          OP_BEQ:       nxt_state = BRANCH;
`ifdef MULTICYCLE_CTRL_JUMP_EN
          OP_J:         nxt_state = JUMP;
`endif
          default: begin
            nxt_state  = FETCH;
            bad_opcode = 1'b1;
          end
        endcase
      end
      MEM_ADR: begin
        if (opcode == OP_SW)      nxt_state = MEM_WR;
        else if (opcode == OP_LW) nxt_state = MEM_RD;
        else                      nxt_state = FETCH;
      end
      MEM_RD:  nxt_state = mem_ready ? MEM_WB : MEM_RD;
      MEM_WB: begin
        nxt_state = FETCH;
        retire    = 1'b1;
      end
      MEM_WR: begin
        nxt_state = mem_ready ? FETCH : MEM_WR;
        retire    = mem_ready;
      end
      EXEC:    nxt_state = ALU_WB;
      ALU_WB: begin
        nxt_state = FETCH;
        retire    = 1'b1;
      end
      BRANCH: begin
        nxt_state = FETCH;
        retire    = 1'b1;
      end
`ifdef MULTICYCLE_CTRL_JUMP_EN
      JUMP: begin
        nxt_state = FETCH;
        retire    = 1'b1;
      end
`endif
      default: nxt_state = FETCH;
    endcase
  end

  // Reset takes priority so an aborted instruction never reaches the counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state   <= FETCH;
      retired_cnt <= '0;
    end else begin
      cur_state <= nxt_state;
      if (retire) retired_cnt <= retired_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    PC_write      = 1'b0;
    PC_write_cond = 1'b0;
    I_or_D        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    IR_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    ALU_src_A     = 1'b0;
    ALU_src_B     = 2'b00;
    ALU_op        = 2'b00;
    PC_source     = 2'b00;
    illegal_op    = 1'b0;
    if (!reset) begin
      case (cur_state)
        FETCH: begin
          mem_read  = 1'b1;
          ALU_src_B = 2'b01;
          IR_write  = mem_ready;
          PC_write  = mem_ready;
        end
        DECODE: begin
          ALU_src_B  = 2'b11;
          illegal_op = bad_opcode;
        end
        MEM_ADR: begin
          ALU_src_A = 1'b1;
          ALU_src_B = 2'b10;
        end
        MEM_RD: begin
          mem_read = 1'b1;
          I_or_D   = 1'b1;
        end
        MEM_WB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
        end
        MEM_WR: begin
          mem_write = 1'b1;
          I_or_D    = 1'b1;
        end
        EXEC: begin
          ALU_src_A = 1'b1;
          ALU_op    = 2'b10;
        end
        ALU_WB: begin
          reg_dst   = 1'b1;
          reg_write = 1'b1;
        end
        BRANCH: begin
          ALU_src_A     = 1'b1;
          ALU_op        = 2'b01;
          PC_write_cond = 1'b1;
          PC_source     = 2'b01;
        end
`ifdef MULTICYCLE_CTRL_JUMP_EN
        JUMP: begin
          PC_write  = 1'b1;
          PC_source = 2'b10;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle state/strobe vectors per instruction class,
// stalls, illegal opcodes, reset abort and counter wrap on a CNT_W=4 instance.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic        mem_ready;

  logic        PC_write, PC_write_cond, I_or_D, mem_read, mem_write, IR_write;
  logic        mem_to_reg, reg_dst, reg_write, ALU_src_A, illegal_op;
  logic [1:0]  ALU_src_B, ALU_op, PC_source;
  logic [3:0]  state;
  logic [15:0] instr_retired;

  logic        d4_PC_write, d4_PC_write_cond, d4_I_or_D, d4_mem_read, d4_mem_write, d4_IR_write;
  logic        d4_mem_to_reg, d4_reg_dst, d4_reg_write, d4_ALU_src_A, d4_illegal_op;
  logic [1:0]  d4_ALU_src_B, d4_ALU_op, d4_PC_source;
  logic [3:0]  d4_state;
  logic [3:0]  d4_instr_retired;

  logic [15:0] strobes;
  assign strobes = {PC_write, PC_write_cond, I_or_D, mem_read, mem_write, IR_write,
                    mem_to_reg, reg_dst, reg_write, ALU_src_A, ALU_src_B, ALU_op, PC_source};

  // {PCw, PCwc, IorD, mrd, mwr, IRw, m2r, rdst, rw, A, B[1:0], op[1:0], src[1:0]}
  localparam logic [15:0] S_ZERO  = 16'b0_0_0_0_0_0_0_0_0_0_00_00_00;
  localparam logic [15:0] S_FRDY  = 16'b1_0_0_1_0_1_0_0_0_0_01_00_00;
  localparam logic [15:0] S_FSTL  = 16'b0_0_0_1_0_0_0_0_0_0_01_00_00;
  localparam logic [15:0] S_DEC   = 16'b0_0_0_0_0_0_0_0_0_0_11_00_00;
  localparam logic [15:0] S_MADR  = 16'b0_0_0_0_0_0_0_0_0_1_10_00_00;
  localparam logic [15:0] S_MRD   = 16'b0_0_1_1_0_0_0_0_0_0_00_00_00;
  localparam logic [15:0] S_MWB   = 16'b0_0_0_0_0_0_1_0_1_0_00_00_00;
  localparam logic [15:0] S_MWR   = 16'b0_0_1_0_1_0_0_0_0_0_00_00_00;
  localparam logic [15:0] S_EXEC  = 16'b0_0_0_0_0_0_0_0_0_1_00_10_00;
  localparam logic [15:0] S_ALUWB = 16'b0_0_0_0_0_0_0_1_1_0_00_00_00;
  localparam logic [15:0] S_BR    = 16'b0_1_0_0_0_0_0_0_0_1_00_01_01;
`ifdef MULTICYCLE_CTRL_JUMP_EN
  localparam logic [15:0] S_JMP   = 16'b1_0_0_0_0_0_0_0_0_0_00_00_10;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_cnt  = '0;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PC_write(PC_write), .PC_write_cond(PC_write_cond), .I_or_D(I_or_D),
    .mem_read(mem_read), .mem_write(mem_write), .IR_write(IR_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .ALU_src_A(ALU_src_A), .ALU_src_B(ALU_src_B), .ALU_op(ALU_op),
    .PC_source(PC_source), .illegal_op(illegal_op), .state(state),
    .instr_retired(instr_retired)
  );

  multicycle_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PC_write(d4_PC_write), .PC_write_cond(d4_PC_write_cond), .I_or_D(d4_I_or_D),
    .mem_read(d4_mem_read), .mem_write(d4_mem_write), .IR_write(d4_IR_write),
    .mem_to_reg(d4_mem_to_reg), .reg_dst(d4_reg_dst), .reg_write(d4_reg_write),
    .ALU_src_A(d4_ALU_src_A), .ALU_src_B(d4_ALU_src_B), .ALU_op(d4_ALU_op),
    .PC_source(d4_PC_source), .illegal_op(d4_illegal_op), .state(d4_state),
    .instr_retired(d4_instr_retired)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b1; opcode = 6'b000000;
    tick(); tick();
    #1;
    n_checks++;
    if ({state, strobes, illegal_op} !== {4'd0, S_ZERO, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: state=%0d strobes=%b illegal=%b, expected state=0 strobes=%b illegal=0",
               state, strobes, illegal_op, S_ZERO);
    end
    n_checks++;
    if ({instr_retired, d4_instr_retired} !== 20'd0) begin
      n_fail++;
      $display("FAIL reset_count: cnt=%0d cnt4=%0d, expected 0 and 0", instr_retired, d4_instr_retired);
    end
    reset = 1'b0;
    exp_cnt = '0;
  endtask

  task automatic test_rtype();
    logic [3:0]  es [4] = '{4'd0, 4'd1, 4'd6, 4'd7};
    logic [15:0] ew [4] = '{S_FRDY, S_DEC, S_EXEC, S_ALUWB};
    opcode = 6'b000000;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1; #1;
      n_checks++;
      if ({state, strobes, illegal_op} !== {es[i], ew[i], 1'b0}) begin
        n_fail++;
        $display("FAIL rtype_c%0d: state=%0d strobes=%b illegal=%b, expected state=%0d strobes=%b illegal=0",
                 i, state, strobes, illegal_op, es[i], ew[i]);
      end
      tick();
    end
    exp_cnt = exp_cnt + 16'd1;
    n_checks++;
    if ({state, instr_retired} !== {4'd0, exp_cnt}) begin
      n_fail++;
      $display("FAIL rtype_retire: state=%0d cnt=%0d, expected state=0 cnt=%0d", state, instr_retired, exp_cnt);
    end
  endtask

  task automatic test_lw_stall();
    logic [3:0]  es [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};
    logic [15:0] ew [7] = '{S_FRDY, S_DEC, S_MADR, S_MRD, S_MRD, S_MRD, S_MWB};
    logic        rd [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    opcode = 6'b100011;
    for (int i = 0; i < 7; i++) begin
      mem_ready = rd[i]; #1;
      n_checks++;
      if ({state, strobes, illegal_op} !== {es[i], ew[i], 1'b0}) begin
        n_fail++;
        $display("FAIL lw_c%0d: state=%0d strobes=%b illegal=%b, expected state=%0d strobes=%b illegal=0",
                 i, state, strobes, illegal_op, es[i], ew[i]);
      end
      tick();
    end
    exp_cnt = exp_cnt + 16'd1;
    n_checks++;
    if ({state, instr_retired} !== {4'd0, exp_cnt}) begin
      n_fail++;
      $display("FAIL lw_retire: state=%0d cnt=%0d, expected state=0 cnt=%0d", state, instr_retired, exp_cnt);
    end
  endtask

  task automatic test_sw();
    logic [3:0]  es [4] = '{4'd0, 4'd1, 4'd2, 4'd5};
    logic [15:0] ew [4] = '{S_FRDY, S_DEC, S_MADR, S_MWR};
    opcode = 6'b101011;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1; #1;
      n_checks++;
      if ({state, strobes, illegal_op} !== {es[i], ew[i], 1'b0}) begin
        n_fail++;
        $display("FAIL sw_c%0d: state=%0d strobes=%b illegal=%b, expected state=%0d strobes=%b illegal=0",
                 i, state, strobes, illegal_op, es[i], ew[i]);
      end
      tick();
    end
    exp_cnt = exp_cnt + 16'd1;
    n_checks++;
    if ({state, mem_write, instr_retired} !== {4'd0, 1'b0, exp_cnt}) begin
      n_fail++;
      $display("FAIL sw_retire: state=%0d mem_write=%b cnt=%0d, expected state=0 mem_write=0 cnt=%0d",
               state, mem_write, instr_retired, exp_cnt);
    end
  endtask

  task automatic test_fetch_stall_beq();
    logic [3:0]  es [5] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd8};
    logic [15:0] ew [5] = '{S_FSTL, S_FSTL, S_FRDY, S_DEC, S_BR};
    logic        rd [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    opcode = 6'b000100;
    for (int i = 0; i < 5; i++) begin
      mem_ready = rd[i]; #1;
      n_checks++;
      if ({state, strobes, illegal_op} !== {es[i], ew[i], 1'b0}) begin
        n_fail++;
        $display("FAIL beq_c%0d: state=%0d strobes=%b illegal=%b, expected state=%0d strobes=%b illegal=0",
                 i, state, strobes, illegal_op, es[i], ew[i]);
      end
      tick();
    end
    exp_cnt = exp_cnt + 16'd1;
    n_checks++;
    if ({state, instr_retired} !== {4'd0, exp_cnt}) begin
      n_fail++;
      $display("FAIL beq_retire: state=%0d cnt=%0d, expected state=0 cnt=%0d", state, instr_retired, exp_cnt);
    end
  endtask

  task automatic test_jump();
`ifdef MULTICYCLE_CTRL_JUMP_EN
    logic [3:0]  es [3] = '{4'd0, 4'd1, 4'd9};
    logic [15:0] ew [3] = '{S_FRDY, S_DEC, S_JMP};
    opcode = 6'b000010;
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b1; #1;
      n_checks++;
      if ({state, strobes, illegal_op} !== {es[i], ew[i], 1'b0}) begin
        n_fail++;
        $display("FAIL jump_c%0d: state=%0d strobes=%b illegal=%b, expected state=%0d strobes=%b illegal=0",
                 i, state, strobes, illegal_op, es[i], ew[i]);
      end
      tick();
    end
    exp_cnt = exp_cnt + 16'd1;
`else
    logic [3:0]  es [2] = '{4'd0, 4'd1};
    logic [15:0] ew [2] = '{S_FRDY, S_DEC};
    logic        ei [2] = '{1'b0, 1'b1};
    opcode = 6'b000010;
    for (int i = 0; i < 2; i++) begin
      mem_ready = 1'b1; #1;
      n_checks++;
      if ({state, strobes, illegal_op} !== {es[i], ew[i], ei[i]}) begin
        n_fail++;
        $display("FAIL jump_illegal_c%0d: state=%0d strobes=%b illegal=%b, expected state=%0d strobes=%b illegal=%b",
                 i, state, strobes, illegal_op, es[i], ew[i], ei[i]);
      end
      tick();
    end
`endif
    n_checks++;
    if ({state, illegal_op, instr_retired} !== {4'd0, 1'b0, exp_cnt}) begin
      n_fail++;
      $display("FAIL jump_end: state=%0d illegal=%b cnt=%0d, expected state=0 illegal=0 cnt=%0d",
               state, illegal_op, instr_retired, exp_cnt);
    end
  endtask

  task automatic test_illegal();
    logic [3:0]  es [2] = '{4'd0, 4'd1};
    logic [15:0] ew [2] = '{S_FRDY, S_DEC};
    logic        ei [2] = '{1'b0, 1'b1};
    opcode = 6'b111111;
    for (int i = 0; i < 2; i++) begin
      mem_ready = 1'b1; #1;
      n_checks++;
      if ({state, strobes, illegal_op} !== {es[i], ew[i], ei[i]}) begin
        n_fail++;
        $display("FAIL illegal_c%0d: state=%0d strobes=%b illegal=%b, expected state=%0d strobes=%b illegal=%b",
                 i, state, strobes, illegal_op, es[i], ew[i], ei[i]);
      end
      tick();
    end
    n_checks++;
    if ({state, illegal_op, instr_retired} !== {4'd0, 1'b0, exp_cnt}) begin
      n_fail++;
      $display("FAIL illegal_end: state=%0d illegal=%b cnt=%0d, expected state=0 illegal=0 cnt=%0d",
               state, illegal_op, instr_retired, exp_cnt);
    end
  endtask

  task automatic test_reset_mid_mem_wr();
    logic [3:0]  es [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5};
    logic [15:0] ew [5] = '{S_FRDY, S_DEC, S_MADR, S_MWR, S_MWR};
    logic        rd [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    opcode = 6'b101011;
    for (int i = 0; i < 5; i++) begin
      mem_ready = rd[i]; #1;
      n_checks++;
      if ({state, strobes, illegal_op} !== {es[i], ew[i], 1'b0}) begin
        n_fail++;
        $display("FAIL swstall_c%0d: state=%0d strobes=%b illegal=%b, expected state=%0d strobes=%b illegal=0",
                 i, state, strobes, illegal_op, es[i], ew[i]);
      end
      tick();
    end
    reset = 1'b1; #1;
    n_checks++;
    if ({state, strobes, illegal_op, instr_retired} !== {4'd5, S_ZERO, 1'b0, exp_cnt}) begin
      n_fail++;
      $display("FAIL reset_in_mem_wr: state=%0d strobes=%b illegal=%b cnt=%0d, expected state=5 strobes=%b illegal=0 cnt=%0d",
               state, strobes, illegal_op, instr_retired, S_ZERO, exp_cnt);
    end
    tick();
    exp_cnt = '0;
    n_checks++;
    if ({state, strobes, instr_retired, d4_instr_retired} !== {4'd0, S_ZERO, 16'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL reset_abort: state=%0d strobes=%b cnt=%0d cnt4=%0d, expected state=0 strobes=%b cnt=0 cnt4=0",
               state, strobes, instr_retired, d4_instr_retired, S_ZERO);
    end
    reset = 1'b0;
  endtask

  task automatic test_wrap();
    opcode = 6'b000000;
    mem_ready = 1'b1;
    for (int n = 0; n < 16; n++) begin
      repeat (4) tick();
      exp_cnt = exp_cnt + 16'd1;
      if (n == 14) begin
        n_checks++;
        if ({state, d4_instr_retired} !== {4'd0, 4'd15}) begin
          n_fail++;
          $display("FAIL wrap_at_max: state=%0d cnt4=%0d, expected state=0 cnt4=15", state, d4_instr_retired);
        end
      end
    end
    n_checks++;
    if ({d4_state, d4_instr_retired, instr_retired} !== {4'd0, 4'd0, exp_cnt}) begin
      n_fail++;
      $display("FAIL wrap_to_zero: state4=%0d cnt4=%0d cnt=%0d, expected state4=0 cnt4=0 cnt=%0d",
               d4_state, d4_instr_retired, instr_retired, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_stall();
    test_sw();
    test_fetch_stall_beq();
    test_jump();
    test_illegal();
    test_reset_mid_mem_wr();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
